// File: rtl/bare_ram_pkg.sv
// Shared constants for the bare dual-port RAM: default geometry, power-up fill
// policy and the word-count helper.
package bare_ram_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SCALE = 10;
  localparam int DEFAULT_INIT  = 0;

  function automatic int bare_ram_depth(input int scale);
    return 1 << scale;
  endfunction

endpackage

// File: rtl/bare_ram.sv
// True dual-port RAM on one shared array with registered read data per port.
// Reads return pre-write data; when both ports write one word, port 1 wins.
module bare_ram
  import bare_ram_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SCALE = DEFAULT_SCALE,
  parameter int INIT  = DEFAULT_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe0,
  input  logic [SCALE-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             we0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             oe1,
  input  logic [SCALE-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we1,
  output logic [WIDTH-1:0] rdata1
);

  localparam int DEPTH = bare_ram_depth(SCALE);
  localparam logic [WIDTH-1:0] INIT_WORD = (INIT != 0) ? '0 : 'x;

  // Power-up content lives in the array declaration so reset never touches it.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: INIT_WORD};

  logic wr0_p0;
  logic wr1_p0;

  assign wr0_p0 = rst && oe0 && we0;
  assign wr1_p0 = rst && oe1 && we1;

  // Array write stage: port 1 is applied last so it owns a same-word collision.
  always_ff @(posedge clk) begin
    if (wr0_p0) mem[addr0] <= wdata0;
    if (wr1_p0) mem[addr1] <= wdata1;
  end

  // Read register stage: samples the array before this edge's writes land.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (oe0) rdata0 <= mem[addr0];
      if (oe1) rdata1 <= mem[addr1];
    end
  end

endmodule

// File: tb/tb_bare_ram.sv
// Randomised and directed bench for bare_ram against a word-array reference model.
module tb_bare_ram;

  localparam int W  = 32;
  localparam int S  = 8;
  localparam int N  = 1 << S;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         oe0 = 1'b0, we0 = 1'b0, oe1 = 1'b0, we1 = 1'b0;
  logic [S-1:0] addr0 = '0, addr1 = '0;
  logic [W-1:0] wdata0 = '0, wdata1 = '0;
  logic [W-1:0] rdata0, rdata1;

  logic         c_oe0 = 1'b0, c_we0 = 1'b0, c_oe1 = 1'b0, c_we1 = 1'b0;
  logic [7:0]   c_addr0 = '0, c_addr1 = '0, c_wdata0 = '0, c_wdata1 = '0;
  logic [7:0]   c_rdata0, c_rdata1;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mdl [N];
  logic [W-1:0] exp0 = '0, exp1 = '0;

  always #5 clk = ~clk;

  bare_ram #(.WIDTH(W), .SCALE(S), .INIT(1)) dut (
    .clk(clk), .rst(rst),
    .oe0(oe0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .rdata0(rdata0),
    .oe1(oe1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .rdata1(rdata1)
  );

  bare_ram #(.WIDTH(8), .SCALE(8), .INIT(1)) dut8 (
    .clk(clk), .rst(rst),
    .oe0(c_oe0), .addr0(c_addr0), .wdata0(c_wdata0), .we0(c_we0), .rdata0(c_rdata0),
    .oe1(c_oe1), .addr1(c_addr1), .wdata1(c_wdata1), .we1(c_we1), .rdata1(c_rdata1)
  );

  // Reference: reads see the array as it was before the edge; writes apply in
  // port order so port 1 overwrites port 0; reset zeroes outputs and blocks writes.
  task automatic tick();
    if (rst) begin
      if (oe0) exp0 = mdl[addr0];
      if (oe1) exp1 = mdl[addr1];
      if (oe0 && we0) mdl[addr0] = wdata0;
      if (oe1 && we1) mdl[addr1] = wdata1;
    end else begin
      exp0 = '0;
      exp1 = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    oe0 = 1'b0; we0 = 1'b0; oe1 = 1'b0; we1 = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (rdata0 !== '0) begin errors++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
    checks++;
    if (rdata1 !== '0) begin errors++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_init_zero();
    c_oe0 = 1'b1; c_we0 = 1'b1; c_addr0 = 8'h10; c_wdata0 = 8'h5A;
    @(posedge clk); #1;
    c_we0 = 1'b0; c_addr0 = 8'h10;
    @(posedge clk); #1;
    checks++;
    if (c_rdata0 !== 8'h5A) begin errors++; $display("FAIL init8_written got=%h exp=5a", c_rdata0); end
    c_addr0 = 8'h00;
    @(posedge clk); #1;
    checks++;
    if (c_rdata0 !== 8'h00) begin errors++; $display("FAIL init8_addr00 got=%h exp=00", c_rdata0); end
    c_addr0 = 8'hFF;
    @(posedge clk); #1;
    checks++;
    if (c_rdata0 !== 8'h00) begin errors++; $display("FAIL init8_addrFF got=%h exp=00", c_rdata0); end
    c_oe0 = 1'b0;
  endtask

  task automatic test_cross_port();
    idle();
    oe0 = 1'b1; we0 = 1'b1; addr0 = 8'd5; wdata0 = 32'hDEADBEEF;
    tick();
    idle();
    oe1 = 1'b1; addr1 = 8'd5;
    tick();
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL cross_read got=%h exp=deadbeef", rdata1); end
    // port 1 reads a word port 0 overwrites in the same cycle
    oe0 = 1'b1; we0 = 1'b1; addr0 = 8'd5; wdata0 = 32'h0BADF00D;
    tick();
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL cross_rdw_old got=%h exp=deadbeef", rdata1); end
    we0 = 1'b0;
    tick();
    checks++;
    if (rdata1 !== 32'h0BADF00D) begin errors++; $display("FAIL cross_rdw_new got=%h exp=0badf00d", rdata1); end
    idle();
  endtask

  task automatic test_rdw_same_port();
    oe0 = 1'b1; we0 = 1'b1; addr0 = 8'd7; wdata0 = 32'h11;
    tick();
    wdata0 = 32'h22;
    tick();
    checks++;
    if (rdata0 !== 32'h11) begin errors++; $display("FAIL rdw_old got=%h exp=11", rdata0); end
    we0 = 1'b0;
    tick();
    checks++;
    if (rdata0 !== 32'h22) begin errors++; $display("FAIL rdw_new got=%h exp=22", rdata0); end
    idle();
  endtask

  task automatic test_dual_write();
    oe0 = 1'b1; we0 = 1'b1; addr0 = 8'd3; wdata0 = 32'hAAAA0000;
    oe1 = 1'b1; we1 = 1'b1; addr1 = 8'd3; wdata1 = 32'h5555FFFF;
    tick();
    we0 = 1'b0; we1 = 1'b0;
    tick();
    checks++;
    if (rdata0 !== 32'h5555FFFF) begin errors++; $display("FAIL dual_write_p0 got=%h exp=5555ffff", rdata0); end
    checks++;
    if (rdata1 !== 32'h5555FFFF) begin errors++; $display("FAIL dual_write_p1 got=%h exp=5555ffff", rdata1); end
    idle();
  endtask

  task automatic test_hold();
    oe0 = 1'b1; we0 = 1'b1; addr0 = 8'd40; wdata0 = 32'h12345678;
    tick();
    we0 = 1'b0;
    tick();
    checks++;
    if (rdata0 !== 32'h12345678) begin errors++; $display("FAIL hold_setup got=%h exp=12345678", rdata0); end
    oe0 = 1'b0; we0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr0 = 8'(40 + i); wdata0 = $urandom;
      tick();
      checks++;
      if (rdata0 !== 32'h12345678) begin errors++; $display("FAIL hold_cycle%0d got=%h exp=12345678", i, rdata0); end
    end
    oe0 = 1'b1; we0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr0 = 8'(40 + i);
      tick();
      checks++;
      if (rdata0 !== exp0) begin errors++; $display("FAIL hold_nowrite%0d got=%h exp=%h", i, rdata0, exp0); end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    oe0 = 1'b1; we0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr0 = 8'(100 + i); wdata0 = 32'hC0DE0000 + 32'(i);
      tick();
    end
    we0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr0 = 8'(100 + i);
      tick();
      checks++;
      if (rdata0 !== 32'hC0DE0000 + 32'(i)) begin
        errors++; $display("FAIL b2b_read%0d got=%h exp=%h", i, rdata0, 32'hC0DE0000 + 32'(i));
      end
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    oe0 = 1'b1; we0 = 1'b1; addr0 = 8'd9; wdata0 = 32'h0000_0909;
    tick();
    wdata0 = 32'hFFFF_9999;
    oe1 = 1'b1; addr1 = 8'd9;
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (rdata0 !== '0) begin errors++; $display("FAIL rstmid_async0 got=%h exp=0", rdata0); end
    checks++;
    if (rdata1 !== '0) begin errors++; $display("FAIL rstmid_async1 got=%h exp=0", rdata1); end
    @(posedge clk); #1;
    exp0 = '0; exp1 = '0;
    checks++;
    if (rdata0 !== '0) begin errors++; $display("FAIL rstmid_held got=%h exp=0", rdata0); end
    rst = 1'b1;
    we0 = 1'b0;
    tick();
    checks++;
    if (rdata0 !== 32'h0000_0909) begin errors++; $display("FAIL rstmid_keep0 got=%h exp=00000909", rdata0); end
    checks++;
    if (rdata1 !== 32'h0000_0909) begin errors++; $display("FAIL rstmid_keep1 got=%h exp=00000909", rdata1); end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      oe0 = 1'($urandom_range(0, 3) != 0);
      oe1 = 1'($urandom_range(0, 3) != 0);
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      addr0 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      addr1 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      wdata0 = $urandom;
      wdata1 = $urandom;
      tick();
      checks++;
      if (rdata0 !== exp0) begin errors++; $display("FAIL rand_p0 cyc=%0d got=%h exp=%h", c, rdata0, exp0); end
      checks++;
      if (rdata1 !== exp1) begin errors++; $display("FAIL rand_p1 cyc=%0d got=%h exp=%h", c, rdata1, exp1); end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < N; i++) mdl[i] = '0;
    test_reset();
    test_init_zero();
    test_cross_port();
    test_rdw_same_port();
    test_dual_write();
    test_hold();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
